gtp_ber_counter: RTL and testbench
==================================

Name: gtp_ber_counter

Overview:
- Bit-error-rate measurement stage on the GTP receive path.
- Compares each valid 16-bit received word against an expected word and forms the mismatch pattern.
- Splits the pattern into two bytes and feeds each byte to its own count_ROM instance (byte popcount, 0..8, asynchronous read).
- Accumulates bit-error and word counts over a programmable window of valid words, then reports the results to the control/readout logic.

Parameters:
- WIN_W, 24, width of the window-length input and the word counter.
- ACC_W, 32, width of the error accumulators; they saturate at all-ones.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that clears the accumulators and arms a new measurement.
- abort  in  1  single-cycle pulse that stops a measurement and returns to IDLE; results are kept.
- win_len  in  WIN_W  number of valid words to measure; sampled on start; 0 is treated as 1.
- rx_valid  in  1  rx_data and exp_data are valid this cycle.
- rx_data  in  16  received word.
- exp_data  in  16  expected word.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle pulse when the final window word has been accumulated.
- bit_err_cnt  out  ACC_W  total mismatched bits in the window.
- word_err_cnt  out  ACC_W  number of words with at least one mismatched bit.
- word_cnt  out  WIN_W  valid words counted so far.
- sat  out  1  sticky; set when either accumulator has saturated.

Behaviour:
- Reset values: every output is 0, the state is IDLE and all pipeline valids are 0.
- States and transitions:
  - IDLE -> RUN on start. The start cycle latches win_len (0 becomes 1) and clears both accumulators, word_cnt and sat.
  - RUN: each cycle with rx_valid=1 advances the pipeline and increments word_cnt.
  - RUN -> DRAIN when word_cnt reaches the window length. The word that reaches it is the last one accepted; rx_valid is ignored from the next cycle onward.
  - DRAIN -> IDLE once the pipeline is empty; done pulses in that cycle.
  - busy=1 in RUN and DRAIN.
- Pipeline, 3 stages, cycle-exact:
  - S1 (registered at the end of the accept cycle): mism = rx_data ^ exp_data, with v1.
  - S2: n = cnt_lo + cnt_hi, 5-bit, range 0..16, taken from the two count_ROM lookups of mism[7:0] and mism[15:8]. Registered with v2 and nz = (mism != 0).
  - S3: on v2, bit_err_cnt += n and word_err_cnt += nz. Both saturate at 2^ACC_W-1 and set sat.
  - Total latency: the accept cycle is T, the accumulator reflects the word at T+3, and done asserts at T+3 for the last word.
- Gaps in rx_valid are allowed; bubbles propagate as v=0 and do not count.
- start while busy: ignored.
- abort has priority over start in the same cycle. On abort, the pipeline is flushed without accumulating, the state goes to IDLE, no done pulse is issued, and the outputs hold.
- start in the same cycle as done: the state goes to RUN. The new clear takes effect that cycle; done still pulses.
- rst mid-measurement: immediate return to reset values next cycle.
- The outputs are stable between measurements and change only in RUN/DRAIN or on the start clear.

Optional Feature:
- Macro: GTP_BER_FIRST_ERR_EN.
- Defined:
  - Adds outputs first_err_idx (WIN_W) and first_err_pat (16).
  - They capture, at S3, the word index (0-based within the window) and the mismatch pattern of the first word with nz=1.
  - They are cleared on start and remain held until the next start.
  - first_err_vld (1) flags a valid capture.
- Undefined: none of these ports or registers exist; all other behaviour is identical.

Test Plan:
- Error-free run: win_len=100, 100 words with rx=exp, contiguous -> done exactly 3 cycles after the 100th accept; bit_err_cnt=0, word_err_cnt=0, word_cnt=100.
- Known pattern: win_len=4, mismatches 0x0001, 0xFFFF, 0x0000, 0x8080 -> bit_err_cnt=19, word_err_cnt=3; with the feature enabled, first_err_idx=0 and first_err_pat=0x0001.
- Bubbles: win_len=3, rx_valid pattern 1,0,0,1,0,1 with 0x00FF mismatch each -> bit_err_cnt=24, done 3 cycles after the third valid, and extra valid words after that are ignored.
- Saturation with ACC_W=8: win_len=20, all words 0xFFFF -> bit_err_cnt=255, sat=1, word_err_cnt=20.
- Abort/restart: abort after 5 of 10 words -> busy falls next cycle, no done pulse, counts held; then start with win_len=0 and one word 0x0003 -> bit_err_cnt=2, word_cnt=1, done pulses.
- Reset mid-run: rst asserted during DRAIN -> all outputs 0 next cycle; done never pulses.

Source files
------------

// File: rtl/gtp_ber_counter.sv
// BER measurement stage: 3-stage compare/popcount/accumulate pipeline over a window of valid words.
// Optional first-error capture is enabled by defining GTP_BER_FIRST_ERR_EN.

module count_ROM (
  input  logic [7:0] addr,
  output logic [3:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, addr[i]};
  end
endmodule

// state | meaning
// IDLE  | waiting for start; results held
// RUN   | accepting valid words until the window is full
// DRAIN | window full; waiting for the pipeline to empty
module gtp_ber_counter #(
  parameter int WIN_W = 24,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             rx_valid,
  input  logic [15:0]      rx_data,
  input  logic [15:0]      exp_data,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] bit_err_cnt,
  output logic [ACC_W-1:0] word_err_cnt,
  output logic [WIN_W-1:0] word_cnt,
  output logic             sat
`ifdef GTP_BER_FIRST_ERR_EN
  ,
  output logic [WIN_W-1:0] first_err_idx,
  output logic [15:0]      first_err_pat,
  output logic             first_err_vld
`endif
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] word_cnt_q, word_cnt_d;
  logic             v1_q, v1_d, v2_q, v2_d, nz_q, nz_d;
  logic [15:0]      mism_q, mism_d;
  logic [4:0]       n_q, n_d;
  logic [ACC_W-1:0] bit_err_q, bit_err_d, word_err_q, word_err_d;
  logic             sat_q, sat_d;
  logic [3:0]       cnt_lo, cnt_hi;
  logic [ACC_W:0]   bit_sum, word_sum;
  logic             accept, start_ok, done_c;
`ifdef GTP_BER_FIRST_ERR_EN
  logic [WIN_W-1:0] idx1_q, idx1_d, idx2_q, idx2_d, fe_idx_q, fe_idx_d;
  logic [15:0]      pat2_q, pat2_d, fe_pat_q, fe_pat_d;
  logic             fe_vld_q, fe_vld_d;
`endif

  count_ROM u_cnt_lo (.addr(mism_q[7:0]),  .cnt(cnt_lo));
  count_ROM u_cnt_hi (.addr(mism_q[15:8]), .cnt(cnt_hi));

  always_comb begin
    state_d    = state_q;
    win_len_d  = win_len_q;
    word_cnt_d = word_cnt_q;
    bit_err_d  = bit_err_q;
    word_err_d = word_err_q;
    sat_d      = sat_q;
    bit_sum    = {1'b0, bit_err_q} + {{(ACC_W-4){1'b0}}, n_q};
    word_sum   = {1'b0, word_err_q} + {{ACC_W{1'b0}}, nz_q};
    done_c     = (state_q == DRAIN) && !v1_q && !v2_q && !abort;
    start_ok   = start && !abort && ((state_q == IDLE) || done_c);
    accept     = (state_q == RUN) && rx_valid && !abort;
    v1_d       = accept;
    mism_d     = rx_data ^ exp_data;
    v2_d       = v1_q && !abort;
    n_d        = {1'b0, cnt_lo} + {1'b0, cnt_hi};
    nz_d       = |mism_q;
`ifdef GTP_BER_FIRST_ERR_EN
    idx1_d   = word_cnt_q;
    idx2_d   = idx1_q;
    pat2_d   = mism_q;
    fe_idx_d = fe_idx_q;
    fe_pat_d = fe_pat_q;
    fe_vld_d = fe_vld_q;
`endif

    // Abort drops in-flight words, so S3 is suppressed in the abort cycle too.
    if (v2_q && !abort) begin
      bit_err_d  = bit_sum[ACC_W] ? '1 : bit_sum[ACC_W-1:0];
      word_err_d = word_sum[ACC_W] ? '1 : word_sum[ACC_W-1:0];
      if (bit_sum[ACC_W] || (&bit_sum[ACC_W-1:0]) ||
          word_sum[ACC_W] || (&word_sum[ACC_W-1:0]))
        sat_d = 1'b1;
`ifdef GTP_BER_FIRST_ERR_EN
      if (nz_q && !fe_vld_q) begin
        fe_idx_d = idx2_q;
        fe_pat_d = pat2_q;
        fe_vld_d = 1'b1;
      end
`endif
    end

    if (accept) begin
      word_cnt_d = word_cnt_q + 1'b1;
      if (word_cnt_d == win_len_q) state_d = DRAIN;
    end

    if (abort && (state_q != IDLE)) state_d = IDLE;
    else if (done_c) state_d = IDLE;

    if (start_ok) begin
      state_d    = RUN;
      win_len_d  = (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
      word_cnt_d = '0;
      bit_err_d  = '0;
      word_err_d = '0;
      sat_d      = 1'b0;
`ifdef GTP_BER_FIRST_ERR_EN
      fe_idx_d = '0;
      fe_pat_d = '0;
      fe_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_len_q  <= '0;
      word_cnt_q <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      nz_q       <= 1'b0;
      mism_q     <= '0;
      n_q        <= '0;
      bit_err_q  <= '0;
      word_err_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_len_q  <= win_len_d;
      word_cnt_q <= word_cnt_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      nz_q       <= nz_d;
      mism_q     <= mism_d;
      n_q        <= n_d;
      bit_err_q  <= bit_err_d;
      word_err_q <= word_err_d;
      sat_q      <= sat_d;
    end
  end

`ifdef GTP_BER_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idx1_q   <= '0;
      idx2_q   <= '0;
      pat2_q   <= '0;
      fe_idx_q <= '0;
      fe_pat_q <= '0;
      fe_vld_q <= 1'b0;
    end else begin
      idx1_q   <= idx1_d;
      idx2_q   <= idx2_d;
      pat2_q   <= pat2_d;
      fe_idx_q <= fe_idx_d;
      fe_pat_q <= fe_pat_d;
      fe_vld_q <= fe_vld_d;
    end
  end

  assign first_err_idx = fe_idx_q;
  assign first_err_pat = fe_pat_q;
  assign first_err_vld = fe_vld_q;
`endif

  assign busy         = (state_q != IDLE);
  assign done         = done_c;
  assign bit_err_cnt  = bit_err_q;
  assign word_err_cnt = word_err_q;
  assign word_cnt     = word_cnt_q;
  assign sat          = sat_q;
endmodule

// File: tb/tb_gtp_ber_counter.sv
// Directed bench for gtp_ber_counter with ACC_W=8 so saturation is reachable.
// First-error outputs are checked when GTP_BER_FIRST_ERR_EN is defined.

module tb_gtp_ber_counter;
  localparam int WIN_W = 24;
  localparam int ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, abort, rx_valid;
  logic [WIN_W-1:0] win_len;
  logic [15:0]      rx_data, exp_data;
  logic             busy, done, sat;
  logic [ACC_W-1:0] bit_err_cnt, word_err_cnt;
  logic [WIN_W-1:0] word_cnt;
`ifdef GTP_BER_FIRST_ERR_EN
  logic [WIN_W-1:0] first_err_idx;
  logic [15:0]      first_err_pat;
  logic             first_err_vld;
`endif

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int done_mark;

  gtp_ber_counter #(.WIN_W(WIN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_len(win_len),
    .rx_valid(rx_valid), .rx_data(rx_data), .exp_data(exp_data),
    .busy(busy), .done(done), .bit_err_cnt(bit_err_cnt),
    .word_err_cnt(word_err_cnt), .word_cnt(word_cnt), .sat(sat)
`ifdef GTP_BER_FIRST_ERR_EN
    , .first_err_idx(first_err_idx), .first_err_pat(first_err_pat),
    .first_err_vld(first_err_vld)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] mism);
    rx_valid = 1'b1;
    rx_data  = 16'($urandom);
    exp_data = rx_data ^ mism;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_start(input logic [WIN_W-1:0] len);
    start   = 1'b1;
    win_len = len;
    step();
    start   = 1'b0;
  endtask

  // Called in the cycle after the last accept; done must appear two cycles later.
  task automatic expect_done(input string tag);
    done_mark = done_pulses;
    check({tag, "_done_t1"}, 64'(done), 64'd0);
    step();
    check({tag, "_done_t2"}, 64'(done), 64'd0);
    step();
    check({tag, "_done_t3"}, 64'(done), 64'd1);
    step();
    check({tag, "_pulses"}, 64'(done_pulses - done_mark), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rx_valid = 1'b0;
    win_len = '0; rx_data = '0; exp_data = '0;
    step(); step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bit", 64'(bit_err_cnt), 64'd0);
    check("rst_word_err", 64'(word_err_cnt), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    rst = 1'b0;
    step();

    // Error-free window of 100; a start mid-run must be ignored.
    do_start(24'd100);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin start = 1'b1; win_len = 24'd5; end
      send_word(16'h0000);
      start = 1'b0;
    end
    expect_done("t1");
    check("t1_bit", 64'(bit_err_cnt), 64'd0);
    check("t1_word_err", 64'(word_err_cnt), 64'd0);
    check("t1_word_cnt", 64'(word_cnt), 64'd100);

    // Known pattern: 1 + 16 + 0 + 2 = 19 bits over 3 erroneous words.
    do_start(24'd4);
    send_word(16'h0001);
    send_word(16'hFFFF);
    send_word(16'h0000);
    send_word(16'h8080);
    expect_done("t2");
    check("t2_bit", 64'(bit_err_cnt), 64'd19);
    check("t2_word_err", 64'(word_err_cnt), 64'd3);
    check("t2_word_cnt", 64'(word_cnt), 64'd4);
`ifdef GTP_BER_FIRST_ERR_EN
    check("t2_fe_vld", 64'(first_err_vld), 64'd1);
    check("t2_fe_idx", 64'(first_err_idx), 64'd0);
    check("t2_fe_pat", 64'(first_err_pat), 64'h0001);
`endif
    for (int i = 0; i < 5; i++) send_word(16'hFFFF);
    check("t2_hold_bit", 64'(bit_err_cnt), 64'd19);
    check("t2_hold_cnt", 64'(word_cnt), 64'd4);

    // Bubbles 1,0,0,1,0,1 then valid words during drain that must be ignored.
    do_start(24'd3);
    send_word(16'h00FF); step(); step();
    send_word(16'h00FF); step();
    send_word(16'h00FF);
    check("t3_done_t1", 64'(done), 64'd0);
    send_word(16'hFFFF);
    check("t3_done_t2", 64'(done), 64'd0);
    send_word(16'hFFFF);
    check("t3_done_t3", 64'(done), 64'd1);
    check("t3_bit", 64'(bit_err_cnt), 64'd24);
    check("t3_word_err", 64'(word_err_cnt), 64'd3);
    check("t3_word_cnt", 64'(word_cnt), 64'd3);
    step();
    check("t3_idle", 64'(busy), 64'd0);

    // Saturation: 20 x 16 bits exceeds 255.
    do_start(24'd20);
    check("t4_clear_bit", 64'(bit_err_cnt), 64'd0);
    for (int i = 0; i < 20; i++) send_word(16'hFFFF);
    expect_done("t4");
    check("t4_bit", 64'(bit_err_cnt), 64'd255);
    check("t4_sat", 64'(sat), 64'd1);
    check("t4_word_err", 64'(word_err_cnt), 64'd20);

    // Abort after 5 of 10 words: only words 1..3 have reached S3.
    do_start(24'd10);
    check("t5_sat_clr", 64'(sat), 64'd0);
    for (int i = 0; i < 5; i++) send_word(16'h0001);
    done_mark = done_pulses;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_word_cnt", 64'(word_cnt), 64'd5);
    check("t5_bit", 64'(bit_err_cnt), 64'd3);
    step(); step(); step();
    check("t5_hold_bit", 64'(bit_err_cnt), 64'd3);
    check("t5_hold_word_err", 64'(word_err_cnt), 64'd3);
    check("t5_no_done", 64'(done_pulses - done_mark), 64'd0);
    do_start(24'd0);
    send_word(16'h0003);
    expect_done("t5r");
    check("t5r_bit", 64'(bit_err_cnt), 64'd2);
    check("t5r_word_cnt", 64'(word_cnt), 64'd1);
    check("t5r_word_err", 64'(word_err_cnt), 64'd1);

    // Reset during drain.
    do_start(24'd2);
    send_word(16'hFFFF);
    send_word(16'hFFFF);
    done_mark = done_pulses;
    check("t6_drain", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_bit", 64'(bit_err_cnt), 64'd0);
    check("t6_word_err", 64'(word_err_cnt), 64'd0);
    check("t6_word_cnt", 64'(word_cnt), 64'd0);
    check("t6_sat", 64'(sat), 64'd0);
    step(); step(); step(); step();
    check("t6_no_done", 64'(done_pulses - done_mark), 64'd0);
    check("t6_bit_late", 64'(bit_err_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
